// File: rtl/riscv_pkg.sv
// riscv_pkg: shared core package.
// Holds the load/store unit typedefs used across the core, including the
// load-size encoding consumed by the writeback arbiter's load formatter.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  // Load size as presented by the LSU on a load return.
  // Encoding 2'b11 is unused by the LSU and is treated as a full word.
  typedef enum logic [1:0] {
    LSU_BYTE = 2'b00,
    LSU_HALF = 2'b01,
    LSU_WORD = 2'b10
  } lsu_type_e;

  // Raw load return as it leaves the memory interface.
  typedef struct packed {
    logic [XLEN-1:0] rdata;
    lsu_type_e       size;
    logic            sign;
    logic [1:0]      offset;
  } lsu_rsp_t;

endpackage

// File: rtl/riscv_wb_fifo.sv
// riscv_wb_fifo: small synchronous FIFO buffering formatted load returns
// until writeback port B is free.
// Ports:
//   clk, rst_n   core clock, asynchronous active-low reset (empties FIFO)
//   push, wdata  write an entry (ignored while full)
//   pop          drop the head entry (ignored while empty)
//   rdata        head entry, valid whenever empty is low
//   full, empty  occupancy flags
module riscv_wb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  // Storage needs no reset: entries are only read once counted in.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/riscv_wb_arbiter.sv
// riscv_wb_arbiter: register-file writeback arbiter with a pending-write
// scoreboard.
// Port A carries single-cycle EX results, registered one cycle.
// Port B carries long-latency results: mul/div has fixed priority over
// buffered, formatted load returns; the winner is registered one cycle.
// A per-register busy bit tracks issued long-latency ops; decode is told to
// stall (hazard_o) while a read address is busy or its write is still in
// flight on either port.
//
// Handshakes: a transfer happens in a cycle where valid and ready are both
// high. ready never depends on valid of the same channel. issue_ready_o
// drops while the destination is busy or being cleared that same cycle;
// lsu_ready_o is "FIFO not full" (a same-cycle pop does not raise it);
// md_ready_o is always high.
//
// Ports: clk, rst_n; ex_* (EX result); issue_* (long-latency issue);
// lsu_* (load return); md_* (mul/div result); raddr_{a,b,c}_i and hazard_o
// (decode); waddr/wdata/we_{a,b}_o (register-file write ports).
module riscv_wb_arbiter
  import riscv_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_we_i,
  input  logic [ADDR_WIDTH-1:0] ex_waddr_i,
  input  logic [DATA_WIDTH-1:0] ex_wdata_i,
  input  logic                  issue_valid_i,
  input  logic [ADDR_WIDTH-1:0] issue_rd_i,
  output logic                  issue_ready_o,
  input  logic                  lsu_valid_i,
  input  logic [ADDR_WIDTH-1:0] lsu_rd_i,
  input  logic [31:0]           lsu_rdata_i,
  input  logic [1:0]            lsu_type_i,
  input  logic                  lsu_sign_i,
  input  logic [1:0]            lsu_offset_i,
  output logic                  lsu_ready_o,
  input  logic                  md_valid_i,
  input  logic [ADDR_WIDTH-1:0] md_rd_i,
  input  logic [DATA_WIDTH-1:0] md_wdata_i,
  output logic                  md_ready_o,
  input  logic [ADDR_WIDTH-1:0] raddr_a_i,
  input  logic [ADDR_WIDTH-1:0] raddr_b_i,
  input  logic [ADDR_WIDTH-1:0] raddr_c_i,
  output logic                  hazard_o,
  output logic [ADDR_WIDTH-1:0] waddr_a_o,
  output logic [DATA_WIDTH-1:0] wdata_a_o,
  output logic                  we_a_o,
  output logic [ADDR_WIDTH-1:0] waddr_b_o,
  output logic [DATA_WIDTH-1:0] wdata_b_o,
  output logic                  we_b_o
);

  localparam int NREG    = 1 << ADDR_WIDTH;
  localparam int ENTRY_W = ADDR_WIDTH + DATA_WIDTH;

  // ---------------- Port A: registered EX result ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_a_o    <= 1'b0;
      waddr_a_o <= '0;
      wdata_a_o <= '0;
    end else begin
      we_a_o    <= ex_we_i && (ex_waddr_i != '0);
      waddr_a_o <= ex_waddr_i;
      wdata_a_o <= ex_wdata_i;
    end
  end

  // ---------------- Load formatting ----------------
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [31:0]           ld_word;
  logic [DATA_WIDTH-1:0] ld_data;

  always_comb begin
    ld_byte = 8'(lsu_rdata_i >> {lsu_offset_i, 3'b000});
    ld_half = lsu_offset_i[1] ? lsu_rdata_i[31:16] : lsu_rdata_i[15:0];
    case (lsu_type_e'(lsu_type_i))
      LSU_BYTE: ld_word = {{24{lsu_sign_i & ld_byte[7]}}, ld_byte};
      LSU_HALF: ld_word = {{16{lsu_sign_i & ld_half[15]}}, ld_half};
      default:  ld_word = lsu_rdata_i;
    endcase
  end

  assign ld_data = DATA_WIDTH'(ld_word);

  // ---------------- Load-return FIFO ----------------
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [ENTRY_W-1:0]    fifo_head;
  logic [ADDR_WIDTH-1:0] head_rd;
  logic [DATA_WIDTH-1:0] head_data;

  assign lsu_ready_o = !fifo_full;
  assign fifo_push   = lsu_valid_i && lsu_ready_o;
  // Mul/div has no buffer of its own, so it always wins port B.
  assign md_ready_o  = 1'b1;
  assign fifo_pop    = !fifo_empty && !md_valid_i;
  assign head_rd     = fifo_head[ENTRY_W-1 -: ADDR_WIDTH];
  assign head_data   = fifo_head[DATA_WIDTH-1:0];

  riscv_wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata ({lsu_rd_i, ld_data}),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // ---------------- Port B: registered winner ----------------
  logic                  win_valid;
  logic [ADDR_WIDTH-1:0] win_rd;
  logic [DATA_WIDTH-1:0] win_data;
  logic                  win_we;

  assign win_valid = md_valid_i || fifo_pop;
  assign win_rd    = md_valid_i ? md_rd_i : head_rd;
  assign win_data  = md_valid_i ? md_wdata_i : head_data;
  assign win_we    = win_valid && (win_rd != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_b_o    <= 1'b0;
      waddr_b_o <= '0;
      wdata_b_o <= '0;
    end else begin
      we_b_o <= win_we;
      if (win_valid) begin
        waddr_b_o <= win_rd;
        wdata_b_o <= win_data;
      end
    end
  end

  // ---------------- Scoreboard ----------------
  logic [NREG-1:0] busy;
  logic            busy_set;

  // Refusing an issue to the register being cleared this cycle keeps at
  // most one pending write per register and avoids a set/clear race.
  assign issue_ready_o = !busy[issue_rd_i] && !(win_we && (win_rd == issue_rd_i));
  assign busy_set      = issue_valid_i && issue_ready_o && (issue_rd_i != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      if (win_we)   busy[win_rd]     <= 1'b0;
      if (busy_set) busy[issue_rd_i] <= 1'b1;
    end
  end

  // ---------------- Decode hazard ----------------
  logic [ADDR_WIDTH-1:0] raddr [3];
  logic [2:0]            hz;

  assign raddr[0] = raddr_a_i;
  assign raddr[1] = raddr_b_i;
  assign raddr[2] = raddr_c_i;

  // A write registered on either port is not readable until the cycle
  // after, so in-flight port writes stall decode as well.
  always_comb begin
    hz = '0;
    for (int i = 0; i < 3; i++) begin
      hz[i] = (raddr[i] != '0) &&
              (busy[raddr[i]] ||
               (we_a_o && (waddr_a_o == raddr[i])) ||
               (we_b_o && (waddr_b_o == raddr[i])));
    end
  end

  assign hazard_o = |hz;

endmodule

// File: doc/riscv_wb_arbiter.md
RISCV_WB_ARBITER -- requirements
Module: riscv_wb_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, default 5, register address width; DATA_WIDTH, default 32, data width; FIFO_DEPTH, default 2, load-return buffer entries.
REQ-002 SHALL have ports, in this order:
- clk  in  1  single core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ex_we_i  in  1  EX single-cycle result valid.
- ex_waddr_i  in  ADDR_WIDTH  EX destination.
- ex_wdata_i  in  DATA_WIDTH  EX result.
- issue_valid_i  in  1  long-latency op (load or mul/div) issued.
- issue_rd_i  in  ADDR_WIDTH  its destination.
- issue_ready_o  out  1  issue accepted.
- lsu_valid_i  in  1  load return valid.
- lsu_rd_i  in  ADDR_WIDTH  load destination.
- lsu_rdata_i  in  32  raw aligned memory word.
- lsu_type_i  in  2  00 byte, 01 half, 10 word.
- lsu_sign_i  in  1  sign-extend.
- lsu_offset_i  in  2  byte offset.
- lsu_ready_o  out  1  load return accepted.
- md_valid_i  in  1  mul/div result valid.
- md_rd_i  in  ADDR_WIDTH  mul/div destination.
- md_wdata_i  in  DATA_WIDTH  mul/div result.
- md_ready_o  out  1  mul/div result accepted.
- raddr_a_i, raddr_b_i, raddr_c_i  in  ADDR_WIDTH each  decode-stage read addresses.
- hazard_o  out  1  decode must stall.
- waddr_a_o  out  ADDR_WIDTH  register-file write port A address.
- wdata_a_o  out  DATA_WIDTH  port A data.
- we_a_o  out  1  port A enable.
- waddr_b_o  out  ADDR_WIDTH  register-file write port B address.
- wdata_b_o  out  DATA_WIDTH  port B data.
- we_b_o  out  1  port B enable.

Function
REQ-003 Port A SHALL register the EX result: we_a_o, waddr_a_o and wdata_a_o in cycle N+1 equal ex_we_i, ex_waddr_i and ex_wdata_i at cycle N; we_a_o is forced 0 when ex_waddr_i==0.
REQ-004 A load return SHALL be accepted when lsu_valid_i && lsu_ready_o; lsu_ready_o = FIFO not full.
REQ-005 On acceptance, the data SHALL be formatted before being pushed into the FIFO:
- byte = rdata[8*offset+7 : 8*offset];
- half = rdata[16*offset[1]+15 : 16*offset[1]];
- the result is sign- or zero-extended per lsu_sign_i;
- lsu_type_i==11 is treated as word.
REQ-006 Port B arbitration SHALL be fixed priority, mul/div over FIFO head:
- md_ready_o = 1 always;
- a FIFO head is popped only in cycles with no md_valid_i.
REQ-007 Port B SHALL be registered: the winner at cycle N appears on we_b_o, waddr_b_o and wdata_b_o at N+1; we_b_o is forced 0 for rd 0.
REQ-008 FIFO latency: an entry accepted into an empty FIFO at cycle N, with no mul/div competition, SHALL be popped at N+1 and written (we_b_o) at N+2.
REQ-009 Full FIFO with simultaneous pop SHALL still hold lsu_ready_o=0 that cycle; ready rises the following cycle.
REQ-010 Scoreboard: a per-register busy bit SHALL be set on issue_valid_i && issue_ready_o for rd!=0 and cleared when port B is loaded for that rd; register 0 is never busy.
REQ-011 issue_ready_o SHALL be 0 when busy[issue_rd_i] is set (no second pending WAW).
REQ-012 A same-cycle clear of register R and issue to R SHALL be refused; the issue is accepted the next cycle.
REQ-013 hazard_o SHALL be 1 when any nonzero raddr_x_i:
- has its busy bit set; or
- equals waddr_a_o with we_a_o set; or
- equals waddr_b_o with we_b_o set (write not yet visible).
REQ-014 A return for a register not marked busy SHALL still be written; no error flag is raised.

Reset
REQ-015 On rst_n low, asynchronously:
- FIFO is emptied and all busy bits are cleared;
- we_a_o, we_b_o = 0; waddr and wdata outputs = 0;
- lsu_ready_o = 1, issue_ready_o = 1, hazard_o = 0.
REQ-016 Reset mid-operation SHALL discard buffered loads without writing them.

Structure
REQ-017 The load-type encoding (byte, half, word) SHALL live in the shared core package riscv_pkg, next to the existing LSU typedefs.
REQ-018 The FIFO SHALL be a sub-module, riscv_wb_fifo (parameterised depth and width, push/pop/full/empty); scoreboard and formatting stay inline.

Verification
REQ-019 EX write rd=5, data 0xDEADBEEF at cycle 3 -> we_a_o=1, waddr_a_o=5, wdata_a_o=0xDEADBEEF at cycle 4.
REQ-020 Load return rdata 0x80FF_1234, byte, signed, offset 3 -> port B data 0xFFFF_FF80; the same with half, unsigned, offset 2 -> 0x0000_80FF.
REQ-021 Issue rd=7; decode raddr_b=7 -> hazard_o=1 until the cycle after we_b_o writes rd 7; a second issue to rd 7 meanwhile -> issue_ready_o=0.
REQ-022 md_valid_i held 3 cycles while 3 loads return -> lsu_ready_o=0 after 2 accepted; mul/div written first; loads drain in order afterwards.
REQ-023 Issue and load return to rd=0 -> no busy set, we_b_o stays 0.
REQ-024 Assert rst_n=0 with 2 buffered loads -> no port B write after release, all busy bits clear.
